axi_rd_burst_bridge: RTL and testbench
======================================

// Module: axi_rd_burst_bridge
// PURPOSE
//  Downstream neighbour of the Dcache read prefetcher: turns its single-outstanding read requests
//  (uncached word, 32B line, 64B double line) into AXI3 AR/R bursts on a 32-bit bus.
//  Collects R beats into a 512-bit return buffer and signals first-half and full completion back.
// PARAMETERS
//  AXI_ID   4'd3   fixed ARID; RID is not checked (one outstanding transaction)
//  ID_W     4      ARID/RID width
// PORTS
//  clk          in   1    clock, all logic on posedge
//  reset        in   1    asynchronous, active-high reset
//  rd_req       in   1    request valid from prefetcher
//  rd_type      in   2    0: uncached word, 1: 32B line (8 beats), 2: 64B double line (16 beats)
//  rd_addr      in   32   byte address; types 1/2 use {rd_addr[31:5],5'b0}
//  rd_rdy       out  1    request accepted when rd_req && rd_rdy
//  ret_half     out  1    1-cycle pulse, type 2 only: ret_data[255:0] valid
//  ret_valid    out  1    1-cycle pulse: transfer complete, ret_data valid
//  ret_data     out  512  beat i at [32*i+31:32*i]; type 0 word at [31:0]
//  arid         out  ID_W = AXI_ID
//  araddr       out  32   burst start address
//  arlen        out  4    0 / 7 / 15 (see split rule)
//  arsize       out  3    always 3'b010
//  arburst      out  2    always 2'b01 (INCR)
//  arvalid      out  1    held until arready
//  arready      in   1
//  rid          in   ID_W ignored
//  rdata        in   32
//  rresp        in   2    ignored
//  rlast        in   1    used only by checker; completion is counter-based
//  rvalid       in   1
//  rready       out  1    = 1 in R state
// BEHAVIOUR
//  Reset: state IDLE, arvalid=0, rready=0, ret_half=0, ret_valid=0, beat counter 0,
//   ret_data=0, rd_rdy=1. Mid-burst reset abandons the transfer; the system resets the AXI slave too.
//  FSM: IDLE -> AR on rd_req&&rd_rdy: latch type, aligned addr; beat_cnt=0.
//   AR: arvalid=1; on arready -> R.
//   R: rready=1; each rvalid stores rdata at ret_data[32*beat_cnt +: 32], beat_cnt++ (5 bits).
//    Last beat of the transfer (type0: 1, type1: 8, type2: 16) -> RET.
//    Type 2 split: at beat 8 of a split transfer -> AR for the second burst.
//   RET: ret_valid=1 for exactly one cycle; rd_rdy=1; rd_req accepted -> AR, else -> IDLE.
//  rd_rdy = (state==IDLE)||(state==RET); accepting in RET is mandatory because the prefetcher
//   reissues on the same cycle it sees ret_valid.
//  ret_half: type 2 only; registered, asserts the cycle after beat 8 (index 7) is stored.
//   Split or not, the 256-bit low half is stable in that cycle.
//  ret_data is registered; it is held until overwritten by the next transfer's beats.
//   The upper half is valid only in the ret_valid cycle of type 2.
//  Latency (arready, rvalid always 1): AR accepted in cycle 1 after acceptance, first beat in cycle 2,
//   ret_valid one cycle after the last beat.
//  4KB rule: type 2 with addr[11:5]==7'h7F is split into two 8-beat bursts.
//   First burst at {addr[31:5],5'b0}, arlen=7; second at {addr[31:12]+1,12'h000}, arlen=7.
//   Otherwise a single 16-beat burst, arlen=15. Types 0/1 never cross a 4KB boundary.
//  Type 0 sends addr unmodified, arlen=0; ret_data[511:32] keep stale contents.
//  rd_type==3 is treated as type 0.
//  rresp/rid errors are not reported; data is passed through.
// STRUCTURE
//  Shared package: RD_UNCACHE/RD_LINE/RD_DLINE type codes, AXI_SIZE_4B, AXI_BURST_INCR,
//   FSM state encodings (one-hot, 4 bits).
//  Single module, no sub-module: FSM, 5-bit beat counter, split flag, 512-bit capture register.
// TESTING
//  type1 addr 0x1000_0024, arready/rvalid always 1 -> araddr 0x1000_0020, arlen 7;
//   ret_valid 1 cycle after beat 8; ret_data[255:0] = beats.
//  type2 addr 0x0000_0040, rdata=beat index -> ret_half 1 cycle after beat 8 with [255:0]=0..7;
//   ret_valid after beat 16 with [511:256]=8..15.
//  type2 addr 0x0000_0FE0 -> two ARs: 0x0FE0 len7, 0x1000 len7; exactly one ret_half, one ret_valid.
//  type0 addr 0x1FAF_0004 -> arlen 0, arsize 2; ret_valid after one beat, ret_data[31:0]=rdata.
//  rd_req held high in RET cycle (type1 -> type2) -> accepted that cycle; next arvalid the following
//   cycle; no lost request. Random arready/rvalid stalls: same data.
//  reset pulsed in R state mid-burst -> all outputs return to reset values immediately
//   (asynchronously), rd_rdy=1.

Source files
------------

// File: rtl/axi_rd_burst_bridge_pkg.sv
// rtl/axi_rd_burst_bridge_pkg.sv - shared codes and state encodings for the read burst bridge
package axi_rd_burst_bridge_pkg;

    localparam logic [1:0] RD_UNCACHE     = 2'd0;
    localparam logic [1:0] RD_LINE        = 2'd1;
    localparam logic [1:0] RD_DLINE       = 2'd2;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_AR   = 4'b0010,
        ST_R    = 4'b0100,
        ST_RET  = 4'b1000
    } state_t;

    // Index of the final beat of a whole transfer (both bursts when split).
    function automatic logic [4:0] last_beat_idx(input logic [1:0] t);
        case (t)
            RD_LINE:  last_beat_idx = 5'd7;
            RD_DLINE: last_beat_idx = 5'd15;
            default:  last_beat_idx = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/axi_rd_burst_bridge.sv
// rtl/axi_rd_burst_bridge.sv - prefetcher read request to AXI3 AR/R burst bridge
module axi_rd_burst_bridge
    import axi_rd_burst_bridge_pkg::*;
#(
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = 4'd3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rd_req,
    input  logic [1:0]      rd_type,
    input  logic [31:0]     rd_addr,
    output logic            rd_rdy,
    output logic            ret_half,
    output logic            ret_valid,
    output logic [511:0]    ret_data,
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [3:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready
);

    state_t         r_state;
    state_t         w_next;
    logic [1:0]     r_type;
    logic [4:0]     r_beat_cnt;
    logic           r_split;
    logic [31:0]    r_araddr;
    logic [3:0]     r_arlen;
    logic [511:0]   r_ret_data;
    logic           r_ret_half;

    logic [1:0]     w_req_type;
    logic           w_accept;
    logic           w_split_req;
    logic           w_beat;
    logic           w_last_beat;
    logic           w_split_point;
    logic           w_unused;

    // Completion is counter-based with a single outstanding transfer, so RID/RRESP/RLAST carry nothing we need.
    assign w_unused      = ^{rid, rresp, rlast};

    assign w_req_type    = (rd_type == 2'd3) ? RD_UNCACHE : rd_type;
    assign w_accept      = rd_req && rd_rdy;
    assign w_split_req   = (w_req_type == RD_DLINE) && (rd_addr[11:5] == 7'h7F);
    assign w_beat        = (r_state == ST_R) && rvalid;
    assign w_last_beat   = (r_beat_cnt == last_beat_idx(r_type));
    assign w_split_point = r_split && (r_beat_cnt == 5'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (rd_req) w_next = ST_AR;
            ST_AR:   if (arready) w_next = ST_R;
            ST_R: begin
                if (rvalid) begin
                    if (w_last_beat) begin
                        w_next = ST_RET;
                    end else if (w_split_point) begin
                        w_next = ST_AR;
                    end
                end
            end
            ST_RET:  w_next = rd_req ? ST_AR : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_type     <= RD_UNCACHE;
            r_beat_cnt <= 5'd0;
            r_split    <= 1'b0;
            r_araddr   <= 32'd0;
            r_arlen    <= 4'd0;
            r_ret_data <= '0;
            r_ret_half <= 1'b0;
        end else begin
            r_ret_half <= 1'b0;
            if (w_accept) begin
                r_type     <= w_req_type;
                r_beat_cnt <= 5'd0;
                r_split    <= w_split_req;
                if (w_req_type == RD_UNCACHE) begin
                    r_araddr <= rd_addr;
                    r_arlen  <= 4'd0;
                end else begin
                    r_araddr <= {rd_addr[31:5], 5'b0};
                    r_arlen  <= ((w_req_type == RD_LINE) || w_split_req) ? 4'd7 : 4'd15;
                end
            end
            if (w_beat) begin
                r_ret_data[{r_beat_cnt[3:0], 5'b0} +: 32] <= rdata;
                r_beat_cnt <= r_beat_cnt + 5'd1;
                if ((r_type == RD_DLINE) && (r_beat_cnt == 5'd7)) begin
                    r_ret_half <= 1'b1;
                end
                // Second half of a 4KB-crossing double line starts at the next page.
                if (w_split_point) begin
                    r_araddr <= {r_araddr[31:12] + 20'd1, 12'h000};
                    r_arlen  <= 4'd7;
                end
            end
        end
    end

    assign rd_rdy    = (r_state == ST_IDLE) || (r_state == ST_RET);
    assign arvalid   = (r_state == ST_AR);
    assign rready    = (r_state == ST_R);
    assign ret_valid = (r_state == ST_RET);
    assign ret_half  = r_ret_half;
    assign ret_data  = r_ret_data;
    assign arid      = AXI_ID;
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = AXI_SIZE_4B;
    assign arburst   = AXI_BURST_INCR;

endmodule

// File: tb/tb_axi_rd_burst_bridge.sv
// tb/tb_axi_rd_burst_bridge.sv - directed self-checking bench for axi_rd_burst_bridge
module tb_axi_rd_burst_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_req;
    logic [1:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_half;
    logic         ret_valid;
    logic [511:0] ret_data;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [3:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    int errors = 0;
    int checks = 0;

    int           n_ar, n_half, n_valid, n_beats;
    int           ar_cyc, half_cyc, valid_cyc, last_beat_cyc, first_beat_cyc;
    logic [31:0]  ar_addr [2];
    logic [3:0]   ar_len  [2];
    logic [2:0]   ar_size;
    logic [1:0]   ar_burst;
    logic [3:0]   ar_id;
    logic [255:0] half_data;
    logic [511:0] snap;
    logic [511:0] exp_data;
    logic         rdy_in_ret;
    logic         timed_out;

    axi_rd_burst_bridge #(.ID_W(4), .AXI_ID(4'd3)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_half(ret_half), .ret_valid(ret_valid), .ret_data(ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    // Acts as the requester and AXI slave; cycle 1 is the first cycle after the accepting edge.
    task automatic do_xfer(input logic [1:0] t, input logic [31:0] a, input bit stall,
                           input logic [31:0] dbase, input bit already,
                           input bit chain, input logic [1:0] ct, input logic [31:0] ca);
        int  cyc;
        int  burst_start;
        bit  done;
        n_ar = 0; n_half = 0; n_valid = 0; n_beats = 0;
        ar_cyc = -1; half_cyc = -1; valid_cyc = -1; last_beat_cyc = -1; first_beat_cyc = -1;
        rdy_in_ret = 1'b0; timed_out = 1'b0; burst_start = 0;
        if (!already) begin
            @(negedge clk);
            rd_req = 1'b1; rd_type = t; rd_addr = a;
            @(posedge clk);
        end
        cyc = 0;
        done = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            rd_req  = 1'b0;
            arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rvalid  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rdata   = dbase + 32'(n_beats);
            rlast   = (n_ar > 0) && ((n_beats - burst_start) == int'(ar_len[n_ar-1]));
            if (arvalid) begin
                if (ar_cyc < 0) ar_cyc = cyc;
                if (arready && n_ar < 2) begin
                    ar_addr[n_ar] = araddr; ar_len[n_ar] = arlen;
                    ar_size = arsize; ar_burst = arburst; ar_id = arid;
                    n_ar++;
                    burst_start = n_beats;
                end
            end
            if (rready && rvalid) begin
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                n_beats++;
            end
            if (ret_half) begin
                n_half++; half_cyc = cyc; half_data = ret_data[255:0];
            end
            if (ret_valid) begin
                n_valid++; valid_cyc = cyc; snap = ret_data; rdy_in_ret = rd_rdy;
                done = 1;
                arready = 1'b0; rvalid = 1'b0;
                if (chain) begin
                    rd_req = 1'b1; rd_type = ct; rd_addr = ca;
                end
                @(posedge clk);
            end
        end
        if (!done) timed_out = 1'b1;
        arready = 1'b0; rvalid = 1'b0;
    endtask

    task automatic build_exp(input logic [31:0] dbase, input int lo, input int n);
        for (int i = 0; i < n; i++) exp_data[32*(lo+i) +: 32] = dbase + 32'(i);
    endtask

    task automatic test_reset;
        reset = 1'b1; rd_req = 1'b0; rd_type = 2'd0; rd_addr = 32'd0;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rlast = 1'b0; rid = 4'd0; rresp = 2'd0;
        repeat (2) @(negedge clk);
        checks++; if ({arvalid, rready, ret_half, ret_valid, rd_rdy} !== 5'b00001) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00001", {arvalid, rready, ret_half, ret_valid, rd_rdy}); end
        checks++; if (ret_data !== 512'd0) begin
            errors++; $display("FAIL reset_data: got %h want 0", ret_data); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (rd_rdy !== 1'b1) begin
            errors++; $display("FAIL idle_rdy: got %b want 1", rd_rdy); end
    endtask

    task automatic test_line;
        do_xfer(2'd1, 32'h1000_0024, 1'b0, 32'hA000_0000, 1'b0, 1'b0, 2'd0, 32'd0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL line_timeout: got %b want 0", timed_out); end
        checks++; if (ar_addr[0] !== 32'h1000_0020 || ar_len[0] !== 4'd7 || n_ar !== 1) begin
            errors++; $display("FAIL line_ar: got addr %h len %0d n %0d want 10000020 7 1", ar_addr[0], ar_len[0], n_ar); end
        checks++; if (ar_size !== 3'b010 || ar_burst !== 2'b01 || ar_id !== 4'd3) begin
            errors++; $display("FAIL line_arattr: got size %b burst %b id %0d want 010 01 3", ar_size, ar_burst, ar_id); end
        checks++; if (ar_cyc !== 1 || first_beat_cyc !== 2 || valid_cyc !== 10) begin
            errors++; $display("FAIL line_latency: got ar %0d beat %0d valid %0d want 1 2 10", ar_cyc, first_beat_cyc, valid_cyc); end
        exp_data = '0; build_exp(32'hA000_0000, 0, 8);
        checks++; if (snap[255:0] !== exp_data[255:0]) begin
            errors++; $display("FAIL line_data: got %h want %h", snap[255:0], exp_data[255:0]); end
        checks++; if (n_half !== 0 || n_valid !== 1) begin
            errors++; $display("FAIL line_pulses: got half %0d valid %0d want 0 1", n_half, n_valid); end
    endtask

    task automatic test_dline;
        do_xfer(2'd2, 32'h0000_0040, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0);
        checks++; if (ar_addr[0] !== 32'h0000_0040 || ar_len[0] !== 4'd15 || n_ar !== 1) begin
            errors++; $display("FAIL dline_ar: got addr %h len %0d n %0d want 40 15 1", ar_addr[0], ar_len[0], n_ar); end
        exp_data = '0; build_exp(32'd0, 0, 16);
        checks++; if (n_half !== 1 || half_cyc !== 10 || half_data !== exp_data[255:0]) begin
            errors++; $display("FAIL dline_half: got n %0d cyc %0d data %h want 1 10 %h", n_half, half_cyc, half_data, exp_data[255:0]); end
        checks++; if (valid_cyc !== 18 || snap !== exp_data) begin
            errors++; $display("FAIL dline_ret: got cyc %0d data %h want 18 %h", valid_cyc, snap, exp_data); end
    endtask

    task automatic test_split;
        do_xfer(2'd2, 32'h0000_0FE0, 1'b0, 32'h5000_0000, 1'b0, 1'b0, 2'd0, 32'd0);
        checks++; if (n_ar !== 2 || ar_addr[0] !== 32'h0000_0FE0 || ar_len[0] !== 4'd7
                      || ar_addr[1] !== 32'h0000_1000 || ar_len[1] !== 4'd7) begin
            errors++; $display("FAIL split_ar: got n %0d %h/%0d %h/%0d want 2 fe0/7 1000/7",
                               n_ar, ar_addr[0], ar_len[0], ar_addr[1], ar_len[1]); end
        exp_data = '0; build_exp(32'h5000_0000, 0, 16);
        checks++; if (n_half !== 1 || half_cyc !== 10 || half_data !== exp_data[255:0]) begin
            errors++; $display("FAIL split_half: got n %0d cyc %0d want 1 10", n_half, half_cyc); end
        checks++; if (n_valid !== 1 || valid_cyc !== 19 || snap !== exp_data) begin
            errors++; $display("FAIL split_ret: got n %0d cyc %0d data %h want 1 19 %h", n_valid, valid_cyc, snap, exp_data); end
    endtask

    task automatic test_back_to_back;
        logic [511:0] prev;
        do_xfer(2'd1, 32'h2000_0000, 1'b0, 32'h1100_0000, 1'b0, 1'b1, 2'd2, 32'h0000_0080);
        checks++; if (rdy_in_ret !== 1'b1 || valid_cyc !== 10) begin
            errors++; $display("FAIL b2b_ret_rdy: got rdy %b cyc %0d want 1 10", rdy_in_ret, valid_cyc); end
        do_xfer(2'd2, 32'h0000_0080, 1'b0, 32'h2200_0000, 1'b1, 1'b0, 2'd0, 32'd0);
        checks++; if (ar_cyc !== 1 || ar_addr[0] !== 32'h0000_0080 || ar_len[0] !== 4'd15) begin
            errors++; $display("FAIL b2b_second_ar: got cyc %0d addr %h len %0d want 1 80 15", ar_cyc, ar_addr[0], ar_len[0]); end
        exp_data = '0; build_exp(32'h2200_0000, 0, 16);
        checks++; if (snap !== exp_data || n_valid !== 1) begin
            errors++; $display("FAIL b2b_second_data: got %h want %h", snap, exp_data); end
        prev = snap;
        do_xfer(2'd0, 32'h1FAF_0004, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0, 2'd0, 32'd0);
        checks++; if (ar_addr[0] !== 32'h1FAF_0004 || ar_len[0] !== 4'd0 || ar_size !== 3'b010) begin
            errors++; $display("FAIL word_ar: got %h len %0d size %b want 1faf0004 0 010", ar_addr[0], ar_len[0], ar_size); end
        checks++; if (valid_cyc !== 3 || snap[31:0] !== 32'hCAFE_0001 || snap[511:32] !== prev[511:32]) begin
            errors++; $display("FAIL word_ret: got cyc %0d word %h want 3 cafe0001 stale upper", valid_cyc, snap[31:0]); end
        do_xfer(2'd3, 32'h0000_0123, 1'b0, 32'h3333_0000, 1'b0, 1'b0, 2'd0, 32'd0);
        checks++; if (ar_addr[0] !== 32'h0000_0123 || ar_len[0] !== 4'd0 || snap[31:0] !== 32'h3333_0000) begin
            errors++; $display("FAIL type3_word: got %h len %0d data %h want 123 0 33330000", ar_addr[0], ar_len[0], snap[31:0]); end
    endtask

    task automatic test_stalls;
        do_xfer(2'd2, 32'h0000_3FE0, 1'b1, 32'h7700_0000, 1'b0, 1'b0, 2'd0, 32'd0);
        exp_data = '0; build_exp(32'h7700_0000, 0, 16);
        checks++; if (timed_out !== 1'b0 || snap !== exp_data || n_ar !== 2 || ar_addr[1] !== 32'h0000_4000) begin
            errors++; $display("FAIL stall_split: got to %b n %0d addr1 %h data %h want 0 2 4000 %h",
                               timed_out, n_ar, ar_addr[1], snap, exp_data); end
        checks++; if (valid_cyc !== last_beat_cyc + 1 || n_half !== 1 || half_cyc <= 0) begin
            errors++; $display("FAIL stall_timing: got valid %0d last %0d half %0d want last+1 1", valid_cyc, last_beat_cyc, n_half); end
        do_xfer(2'd1, 32'h4000_005C, 1'b1, 32'h9900_0000, 1'b0, 1'b0, 2'd0, 32'd0);
        exp_data = '0; build_exp(32'h9900_0000, 0, 8);
        checks++; if (ar_addr[0] !== 32'h4000_0040 || snap[255:0] !== exp_data[255:0]) begin
            errors++; $display("FAIL stall_line: got addr %h data %h want 40000040 %h", ar_addr[0], snap[255:0], exp_data[255:0]); end
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        rd_req = 1'b1; rd_type = 2'd2; rd_addr = 32'h0000_0040;
        @(posedge clk);
        @(negedge clk);
        rd_req = 1'b0; arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        repeat (4) @(negedge clk);
        checks++; if (rready !== 1'b1) begin
            errors++; $display("FAIL pre_reset_in_r: got rready %b want 1", rready); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({arvalid, rready, ret_half, ret_valid, rd_rdy} !== 5'b00001) begin
            errors++; $display("FAIL async_reset_ctrl: got %b want 00001", {arvalid, rready, ret_half, ret_valid, rd_rdy}); end
        checks++; if (ret_data !== 512'd0) begin
            errors++; $display("FAIL async_reset_data: got %h want 0", ret_data); end
        @(negedge clk);
        reset = 1'b0; arready = 1'b0; rvalid = 1'b0;
        do_xfer(2'd1, 32'h0000_0100, 1'b0, 32'h6000_0000, 1'b0, 1'b0, 2'd0, 32'd0);
        checks++; if (ar_cyc !== 1 || valid_cyc !== 10 || snap[31:0] !== 32'h6000_0000) begin
            errors++; $display("FAIL post_reset_xfer: got ar %0d valid %0d d0 %h want 1 10 60000000", ar_cyc, valid_cyc, snap[31:0]); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_dline();
        test_split();
        test_back_to_back();
        test_stalls();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
